// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the init-bridge, stream-read and SDRAM bridge-slave signals around the port arbiter.
// slave = arbiter side, master = requesters plus bridge side.
interface sdram_port_arbiter_if;
    logic        init_bus_enable;
    logic        init_rw;
    logic [25:0] init_address;
    logic [1:0]  init_byte_enable;
    logic [15:0] init_write_data;
    logic        init_acknowledge;
    logic [15:0] init_read_data;

    logic        strm_req;
    logic [25:0] strm_addr;
    logic        strm_ack;
    logic [15:0] strm_rdata;

    logic [25:0] ar_addr;
    logic [1:0]  ar_be;
    logic        ar_read;
    logic        ar_write;
    logic [15:0] ar_wrdata;
    logic        ar_ac;
    logic [15:0] ar_rddata;

    modport slave (
        input  init_bus_enable, init_rw, init_address, init_byte_enable, init_write_data,
        output init_acknowledge, init_read_data,
        input  strm_req, strm_addr,
        output strm_ack, strm_rdata,
        output ar_addr, ar_be, ar_read, ar_write, ar_wrdata,
        input  ar_ac, ar_rddata
    );

    modport master (
        output init_bus_enable, init_rw, init_address, init_byte_enable, init_write_data,
        input  init_acknowledge, init_read_data,
        output strm_req, strm_addr,
        input  strm_ack, strm_rdata,
        input  ar_addr, ar_be, ar_read, ar_write, ar_wrdata,
        output ar_ac, ar_rddata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter (init bridge + stream read port) serialising single-word SDRAM bridge
// transactions; stream has priority, bounded by a starvation limit, with a transfer watchdog.
module sdram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                 Clk,
    input  logic                 Reset,
    sdram_port_arbiter_if.slave  bus,
    output logic                 timeout_err
);
    localparam int SW = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WDOG_MAX   = WW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t        r_state, w_next_state;
    logic          r_owner_init;
    logic [SW-1:0] r_starve_cnt;
    logic [WW-1:0] r_wdog;
    logic [25:0]   r_addr;
    logic [1:0]    r_be;
    logic          r_read, r_write;
    logic [15:0]   r_wrdata;
    logic          r_init_ack, r_strm_ack;
    logic [15:0]   r_init_rdata, r_strm_rdata;
    logic          r_timeout_err;

    logic w_grant_strm, w_grant_init, w_done, w_abort;

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_strm = 1'b0;
        w_grant_init = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.strm_req && !(bus.init_bus_enable && r_starve_cnt == STARVE_MAX))
                    w_grant_strm = 1'b1;
                else if (bus.init_bus_enable)
                    w_grant_init = 1'b1;
                if (w_grant_strm || w_grant_init) w_next_state = XFER;
            end
            XFER: begin
                // a bridge ack on the watchdog limit cycle still counts as normal completion
                if (bus.ar_ac)               w_done  = 1'b1;
                else if (r_wdog == WDOG_MAX) w_abort = 1'b1;
                if (w_done || w_abort) w_next_state = RESP;
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_owner_init  <= 1'b0;
            r_starve_cnt  <= '0;
            r_wdog        <= '0;
            r_addr        <= '0;
            r_be          <= '0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_wrdata      <= '0;
            r_init_ack    <= 1'b0;
            r_strm_ack    <= 1'b0;
            r_init_rdata  <= '0;
            r_strm_rdata  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_init_ack <= 1'b0;
            r_strm_ack <= 1'b0;

            if (w_grant_strm || w_grant_init) begin
                r_owner_init <= w_grant_init;
                r_addr       <= w_grant_init ? bus.init_address : bus.strm_addr;
                r_be         <= w_grant_init ? bus.init_byte_enable : 2'b11;
                r_wrdata     <= w_grant_init ? bus.init_write_data : '0;
                r_read       <= w_grant_strm || bus.init_rw;
                r_write      <= w_grant_init && !bus.init_rw;
                r_wdog       <= WW'(1);
            end

            if (r_state == XFER && !(w_done || w_abort))
                r_wdog <= r_wdog + WW'(1);

            if (w_done || w_abort) begin
                r_read     <= 1'b0;
                r_write    <= 1'b0;
                r_init_ack <= r_owner_init;
                r_strm_ack <= !r_owner_init;
                if (r_owner_init) r_init_rdata <= w_done ? bus.ar_rddata : '0;
                else              r_strm_rdata <= w_done ? bus.ar_rddata : '0;
                if (w_abort) r_timeout_err <= 1'b1;
            end

            // counts stream wins over a waiting init; any idle cycle without init resets it
            if (r_state == IDLE) begin
                if (!bus.init_bus_enable || w_grant_init)
                    r_starve_cnt <= '0;
                else if (w_grant_strm && r_starve_cnt != STARVE_MAX)
                    r_starve_cnt <= r_starve_cnt + SW'(1);
            end
        end
    end

    assign bus.ar_addr          = r_addr;
    assign bus.ar_be            = r_be;
    assign bus.ar_read          = r_read;
    assign bus.ar_write         = r_write;
    assign bus.ar_wrdata        = r_wrdata;
    assign bus.init_acknowledge = r_init_ack;
    assign bus.init_read_data   = r_init_rdata;
    assign bus.strm_ack         = r_strm_ack;
    assign bus.strm_rdata       = r_strm_rdata;
    assign timeout_err          = r_timeout_err;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed vector table, starvation/timeout/reset sequences,
// and randomized traffic checked against a transaction-level arbitration model.
module tb_sdram_port_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic Clk = 1'b0;
    logic Reset;
    logic timeout_err;

    sdram_port_arbiter_if bus();

    sdram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus.slave),
        .timeout_err(timeout_err)
    );

    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // held request state of the two requesters
    bit          i_pend, i_rw, s_pend;
    logic [25:0] i_addr, s_addr;
    logic [1:0]  i_be;
    logic [15:0] i_wd;
    int          starve;

    typedef struct {
        bit          owner_init;
        bit          rd;
        bit          wr;
        logic [25:0] addr;
        logic [1:0]  be;
        logic [15:0] wd;
    } cmd_t;

    typedef struct {
        bit          is_init;
        bit          rw;
        logic [25:0] addr;
        logic [1:0]  be;
        logic [15:0] wd;
        int          xcyc;
        logic [15:0] rd;
        bit          exp_read;
        bit          exp_write;
        logic [1:0]  exp_be;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[5];
    bit   pat[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus.init_bus_enable  = i_pend;
        bus.init_rw          = i_rw;
        bus.init_address     = i_addr;
        bus.init_byte_enable = i_be;
        bus.init_write_data  = i_wd;
        bus.strm_req         = s_pend;
        bus.strm_addr        = s_addr;
    endtask

    task automatic new_init();
        i_pend = 1'b1;
        i_rw   = 1'($urandom);
        i_addr = 26'($urandom);
        i_be   = 2'($urandom);
        i_wd   = 16'($urandom);
    endtask

    task automatic new_strm();
        s_pend = 1'b1;
        s_addr = 26'($urandom);
    endtask

    function automatic cmd_t expect_cmd(input bit own_init);
        cmd_t c;
        if (own_init) c = '{1'b1, i_rw, !i_rw, i_addr, i_be, i_wd};
        else          c = '{1'b0, 1'b1, 1'b0, s_addr, 2'b11, 16'h0000};
        return c;
    endfunction

    // Called at the negedge of an IDLE cycle with requests already driven.
    task automatic serve(input cmd_t e, input int xcyc, input bit hang, input logic [15:0] rd);
        logic [15:0] exp_data;
        exp_data = hang ? 16'h0000 : rd;
        @(negedge Clk);
        for (int k = 1; k <= xcyc; k++) begin
            chk("ar_read",   32'(bus.ar_read),  32'(e.rd));
            chk("ar_write",  32'(bus.ar_write), 32'(e.wr));
            chk("ar_addr",   32'(bus.ar_addr),  32'(e.addr));
            chk("ar_be",     32'(bus.ar_be),    32'(e.be));
            if (e.wr) chk("ar_wrdata", 32'(bus.ar_wrdata), 32'(e.wd));
            chk("ack_early", 32'({bus.init_acknowledge, bus.strm_ack}), 32'd0);
            if (k == xcyc && !hang) begin
                bus.ar_ac     = 1'b1;
                bus.ar_rddata = rd;
            end else begin
                bus.ar_rddata = 16'($urandom);
            end
            @(negedge Clk);
        end
        bus.ar_ac     = 1'b0;
        bus.ar_rddata = 16'($urandom);
        chk("cmd_drop", 32'({bus.ar_read, bus.ar_write}), 32'd0);
        chk("init_ack", 32'(bus.init_acknowledge), 32'(e.owner_init));
        chk("strm_ack", 32'(bus.strm_ack), 32'(!e.owner_init));
        if (e.owner_init) chk("init_rdata", 32'(bus.init_read_data), 32'(exp_data));
        else              chk("strm_rdata", 32'(bus.strm_rdata), 32'(exp_data));
    endtask

    task automatic post_check();
        @(negedge Clk);
        chk("ack_pulse", 32'({bus.init_acknowledge, bus.strm_ack}), 32'd0);
        chk("cmd_idle",  32'({bus.ar_read, bus.ar_write}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        cmd_t e;
        bit   win;

        vecs[0] = '{1'b1, 1'b0, 26'h0000100, 2'b11, 16'hBEEF, 3, 16'h5A5A, 1'b0, 1'b1, 2'b11, 16'h5A5A};
        vecs[1] = '{1'b0, 1'b1, 26'h0000200, 2'b00, 16'h0000, 1, 16'h1234, 1'b1, 1'b0, 2'b11, 16'h1234};
        vecs[2] = '{1'b1, 1'b1, 26'h3FFFFFF, 2'b01, 16'h0000, 2, 16'hFFFF, 1'b1, 1'b0, 2'b01, 16'hFFFF};
        vecs[3] = '{1'b1, 1'b0, 26'h0000000, 2'b10, 16'h0000, 1, 16'hC3C3, 1'b0, 1'b1, 2'b10, 16'hC3C3};
        vecs[4] = '{1'b0, 1'b1, 26'h3FFFFFF, 2'b01, 16'hFFFF, 4, 16'h0001, 1'b1, 1'b0, 2'b11, 16'h0001};
        pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        Reset = 1'b1;
        i_pend = 1'b0; s_pend = 1'b0; i_rw = 1'b0;
        i_addr = '0; s_addr = '0; i_be = '0; i_wd = '0;
        starve = 0;
        drive();
        bus.ar_ac = 1'b0;
        bus.ar_rddata = '0;
        repeat (2) @(negedge Clk);
        chk("rst_ar_read",   32'(bus.ar_read), 32'd0);
        chk("rst_ar_write",  32'(bus.ar_write), 32'd0);
        chk("rst_ar_addr",   32'(bus.ar_addr), 32'd0);
        chk("rst_ar_be",     32'(bus.ar_be), 32'd0);
        chk("rst_ar_wrdata", 32'(bus.ar_wrdata), 32'd0);
        chk("rst_acks",      32'({bus.init_acknowledge, bus.strm_ack}), 32'd0);
        chk("rst_init_rd",   32'(bus.init_read_data), 32'd0);
        chk("rst_strm_rd",   32'(bus.strm_rdata), 32'd0);
        chk("rst_timeout",   32'(timeout_err), 32'd0);
        Reset = 1'b0;

        // directed single-requester vectors
        for (int v = 0; v < 5; v++) begin
            i_pend = vecs[v].is_init;
            s_pend = !vecs[v].is_init;
            i_rw = vecs[v].rw; i_addr = vecs[v].addr; i_be = vecs[v].be; i_wd = vecs[v].wd;
            s_addr = vecs[v].addr;
            drive();
            e = '{vecs[v].is_init, vecs[v].exp_read, vecs[v].exp_write,
                  vecs[v].addr, vecs[v].exp_be, vecs[v].wd};
            serve(e, vecs[v].xcyc, 1'b0, vecs[v].rd);
            if (vecs[v].is_init) chk("tbl_init_data", 32'(bus.init_read_data), 32'(vecs[v].exp_data));
            else                 chk("tbl_strm_data", 32'(bus.strm_rdata), 32'(vecs[v].exp_data));
            i_pend = 1'b0; s_pend = 1'b0;
            drive();
            post_check();
        end

        // both masters requesting continuously: S,S,S,S,I repeating
        i_pend = 1'b1; i_rw = 1'b1; i_addr = 26'h00000AA; i_be = 2'b11; i_wd = 16'h0;
        s_pend = 1'b1; s_addr = 26'h0000055;
        drive();
        for (int n = 0; n < 10; n++) begin
            serve(expect_cmd(pat[n]), 1, 1'b0, 16'(n * 7 + 1));
            post_check();
        end
        i_pend = 1'b0; s_pend = 1'b0; starve = 0;
        drive();

        // randomized traffic against the arbitration model
        for (int n = 0; n < 300; n++) begin
            if (!i_pend && ($urandom_range(0, 1) == 1)) new_init();
            if (!s_pend && ($urandom_range(0, 3) != 0)) new_strm();
            drive();
            if (!i_pend && !s_pend) begin
                starve = 0;
                @(negedge Clk);
                chk("rnd_idle", 32'({bus.ar_read, bus.ar_write}), 32'd0);
                continue;
            end
            if (i_pend && s_pend) win = (starve == STARVE_LIMIT);
            else                  win = i_pend;
            if (!i_pend || win) starve = 0;
            else if (starve < STARVE_LIMIT) starve++;
            serve(expect_cmd(win), $urandom_range(1, 4), 1'b0, 16'($urandom));
            if (win) begin
                if ($urandom_range(0, 1) == 1) new_init(); else i_pend = 1'b0;
            end else begin
                if ($urandom_range(0, 3) != 0) new_strm(); else s_pend = 1'b0;
            end
            drive();
            post_check();
        end
        i_pend = 1'b0; s_pend = 1'b0; starve = 0;
        drive();
        @(negedge Clk);

        // bridge ack on the watchdog limit cycle completes normally
        i_pend = 1'b1; i_rw = 1'b1; i_addr = 26'h0123456; i_be = 2'b11; i_wd = 16'h0;
        drive();
        serve(expect_cmd(1'b1), TIMEOUT, 1'b0, 16'hA55A);
        i_pend = 1'b0; drive();
        post_check();
        chk("limit_ack_no_err", 32'(timeout_err), 32'd0);

        // bridge never acks: abort with zero data and sticky error
        i_pend = 1'b1; i_rw = 1'b1; i_addr = 26'h0000300;
        drive();
        serve(expect_cmd(1'b1), TIMEOUT, 1'b1, 16'h0000);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        i_pend = 1'b0; drive();
        post_check();
        s_pend = 1'b1; s_addr = 26'h0000400; drive();
        serve(expect_cmd(1'b0), 2, 1'b0, 16'h7777);
        s_pend = 1'b0; drive();
        post_check();
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // reset during the second XFER cycle
        s_pend = 1'b1; s_addr = 26'h0000500; drive();
        @(negedge Clk);
        @(negedge Clk);
        chk("pre_rst_read", 32'(bus.ar_read), 32'd1);
        Reset = 1'b1;
        s_pend = 1'b0; drive();
        @(negedge Clk);
        chk("mid_rst_cmd",     32'({bus.ar_read, bus.ar_write}), 32'd0);
        chk("mid_rst_addr",    32'(bus.ar_addr), 32'd0);
        chk("mid_rst_be",      32'(bus.ar_be), 32'd0);
        chk("mid_rst_acks",    32'({bus.init_acknowledge, bus.strm_ack}), 32'd0);
        chk("mid_rst_strm_rd", 32'(bus.strm_rdata), 32'd0);
        chk("mid_rst_timeout", 32'(timeout_err), 32'd0);
        Reset = 1'b0;
        post_check();
        i_pend = 1'b1; i_rw = 1'b0; i_addr = 26'h0000600; i_be = 2'b11; i_wd = 16'hCAFE;
        drive();
        serve(expect_cmd(1'b1), 1, 1'b0, 16'h0F0F);
        i_pend = 1'b0; drive();
        post_check();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-master arbiter in front of the SDRAM controller's bridge slave port (`ar_*` signals). It merges the SoC init bridge (Nios-driven loading of song/chart data into SDRAM) with a streaming read port used by the audio/chart fetch logic, and serialises them into single-word bridge transactions. The stream port has priority for audio latency; a starvation limit guarantees init progress; a watchdog aborts hung transfers.

## Interface
- `STARVE_LIMIT`, 4 — consecutive stream grants allowed while init waits before init is forced.
- `TIMEOUT`, 1024 — XFER cycles without `ar_acknowledge` before abort.
- `Clk` in 1 — system clock (50 MHz).
- `Reset` in 1 — synchronous, active-high.
- `init_bus_enable` in 1 — init request, held until acknowledged.
- `init_rw` in 1 — 1 = read, 0 = write.
- `init_address` in 26 — init word address.
- `init_byte_enable` in 2 — init byte lanes.
- `init_write_data` in 16 — init write data.
- `init_acknowledge` out 1 — one-cycle completion pulse to init.
- `init_read_data` out 16 — read data, valid with `init_acknowledge`.
- `strm_req` in 1 — stream read request, held until acknowledged.
- `strm_addr` in 26 — stream word address.
- `strm_ack` out 1 — one-cycle completion pulse to stream.
- `strm_rdata` out 16 — read data, valid with `strm_ack`.
- `ar_addr` out 26, `ar_be` out 2, `ar_read` out 1, `ar_write` out 1, `ar_wrdata` out 16 — bridge command, all registered.
- `ar_ac` in 1 — bridge acknowledge.
- `ar_rddata` in 16 — bridge read data, valid with `ar_ac`.
- `timeout_err` out 1 — sticky abort flag.

## Operation
- States: IDLE, XFER, RESP. Reset → IDLE.
- IDLE: sample requests. Neither → stay. Only one → grant it. Both → grant stream unless `starve_cnt == STARVE_LIMIT`, then grant init.
- Grant: latch owner, address, byte enable (stream: 2'b11), write data, direction (stream: always read) into `ar_*` registers; go XFER.
- XFER: `ar_read` or `ar_write` high (never both); `ar_*` stable. On `ar_ac`: capture `ar_rddata` (writes: capture anyway), → RESP. Else if watchdog reaches `TIMEOUT`: drop command, capture data = 16'h0000, set `timeout_err`, → RESP.
- RESP: pulse owner's ack for one cycle with captured data on its data output; → IDLE. Non-owner ack stays 0.
- `starve_cnt` (3+ bits, saturating at STARVE_LIMIT): +1 on each stream grant issued while `init_bus_enable` is high; cleared on init grant or whenever `init_bus_enable` is low in IDLE.
- `ar_ac` outside XFER ignored. Request inputs outside IDLE ignored (requesters must hold them).
- Requesters drop/replace their request on the edge after their ack; the RESP→IDLE bubble guarantees no double service.
- `timeout_err` cleared only by `Reset`.

## Timing
- Reset values: all `ar_*` 0, both acks 0, both read-data outputs 0, `timeout_err` 0, `starve_cnt` 0, state IDLE.
- Request seen in IDLE at cycle N → `ar_read`/`ar_write` high from N+1.
- `ar_ac` at cycle M → command low at M+1, owner ack high exactly at M+1, IDLE at M+2. Minimum request-to-ack: 2 cycles (ack in first XFER cycle). Back-to-back throughput: one transaction per 3 cycles minimum.
- Watchdog counts XFER cycles from 1; abort when count reaches `TIMEOUT` with `ar_ac` low; `ar_ac` in the same cycle as the limit wins (normal completion).
- Reset mid-XFER: command drops at the next edge, no ack issued, pending transaction discarded.

## Test plan
- Init write addr 26'h0000100, data 16'hBEEF, be 2'b11, bridge acks after 3 cycles → `ar_write` high 3 cycles with those values, `init_acknowledge` one pulse, `strm_ack` 0.
- Stream read addr 26'h0000200, bridge returns 16'h1234 on first XFER cycle → `strm_ack` at request+2 with `strm_rdata`=16'h1234, `ar_be`=2'b11.
- Both requesting continuously, STARVE_LIMIT=4 → grant order S,S,S,S,I,S,S,S,S,I…
- Bridge never acks, TIMEOUT=16 → command held 16 cycles then drops, owner ack with data 16'h0000, `timeout_err`=1 until Reset.
- `Reset` asserted in second XFER cycle → all `ar_*` 0 next edge, no ack pulse, next request serviced normally.
